// File: rtl/mem_pkg.sv
// Shared definitions for the TinyRV1 memory responder: request encodings,
// store-buffer entry layout and the address range check.
package mem_pkg;

  localparam logic MEM_REQ_READ  = 1'b0;
  localparam logic MEM_REQ_WRITE = 1'b1;

  // Widest word index a 32-bit byte address can carry. Entries hold the index
  // zero-extended to this width so the typedef is independent of ADDR_W.
  localparam int unsigned SB_IDX_W = 30;

  typedef struct packed {
    logic                valid;
    logic [SB_IDX_W-1:0] idx;
    logic [31:0]         data;
  } sb_entry_t;

  // True when every byte-address bit above the RAM word index is zero.
  function automatic logic in_range(input logic [31:0] addr,
                                    input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (hi == '0);
  endfunction

endpackage

// File: rtl/store_buffer.sv
// FIFO store buffer with push/pop, an occupancy count and two independent
// youngest-match forwarding lookups (instruction and data read ports).
module store_buffer
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic [ADDR_W-1:0]           i_push_idx,
  input  logic [31:0]                 i_push_data,
  input  logic                        i_pop,
  output logic [ADDR_W-1:0]           o_head_idx,
  output logic [31:0]                 o_head_data,
  output logic [$clog2(SB_DEPTH):0]   o_count,
  input  logic [ADDR_W-1:0]           i_lka_idx,
  output logic                        o_lka_hit,
  output logic [31:0]                 o_lka_data,
  input  logic [ADDR_W-1:0]           i_lkb_idx,
  output logic                        o_lkb_hit,
  output logic [31:0]                 o_lkb_data
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t          r_ent [SB_DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic [SB_IDX_W-1:0] w_lka_key;
  logic [SB_IDX_W-1:0] w_lkb_key;

  assign w_lka_key   = SB_IDX_W'(i_lka_idx);
  assign w_lkb_key   = SB_IDX_W'(i_lkb_idx);
  assign o_head_idx  = r_ent[r_head].idx[ADDR_W-1:0];
  assign o_head_data = r_ent[r_head].data;
  assign o_count     = r_count;

  // FIFO state: pop is applied before push so that when full the freed head
  // slot (which equals the tail slot) is refilled by the incoming store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SB_DEPTH; i++) r_ent[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_pop) begin
        r_ent[r_head].valid <= 1'b0;
        r_head              <= r_head + 1'b1;
      end
      if (i_push) begin
        r_ent[r_tail] <= '{valid: 1'b1, idx: SB_IDX_W'(i_push_idx), data: i_push_data};
        r_tail        <= r_tail + 1'b1;
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // Forwarding: scan oldest to youngest from the head so later hits win.
  always_comb begin
    logic [PTR_W-1:0] ptr;
    o_lka_hit  = 1'b0;
    o_lka_data = '0;
    o_lkb_hit  = 1'b0;
    o_lkb_data = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      ptr = r_head + PTR_W'(i);
      if (r_ent[ptr].valid && (r_ent[ptr].idx == w_lka_key)) begin
        o_lka_hit  = 1'b1;
        o_lka_data = r_ent[ptr].data;
      end
      if (r_ent[ptr].valid && (r_ent[ptr].idx == w_lkb_key)) begin
        o_lkb_hit  = 1'b1;
        o_lkb_data = r_ent[ptr].data;
      end
    end
  end

endmodule

// File: rtl/proc_mem_responder.sv
// Memory-side responder for the TinyRV1 imem/dmem ports: word RAM with two
// combinational read ports, a buffered store path with forwarding, and a
// host loader sharing the single RAM write port.
module proc_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      imemreq_val,
  input  logic [31:0]               imemreq_addr,
  output logic [31:0]               imemresp_data,
  input  logic                      dmemreq_val,
  input  logic                      dmemreq_type,
  input  logic [31:0]               dmemreq_addr,
  input  logic [31:0]               dmemreq_wdata,
  output logic [31:0]               dmemresp_rdata,
  input  logic                      hostreq_val,
  output logic                      hostreq_rdy,
  input  logic [31:0]               hostreq_addr,
  input  logic [31:0]               hostreq_wdata,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      addr_err
);

  localparam int unsigned CNT_W = $clog2(SB_DEPTH) + 1;

  logic [31:0]       r_ram [2**ADDR_W];
  logic              r_addr_err;

  logic [ADDR_W-1:0] w_i_idx;
  logic [ADDR_W-1:0] w_d_idx;
  logic [ADDR_W-1:0] w_h_idx;
  logic              w_i_inr;
  logic              w_d_inr;
  logic              w_h_inr;
  logic              w_store;
  logic              w_full;
  logic              w_drain;
  logic              w_host_wr;
  logic              w_err_set;
  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_head_idx;
  logic [31:0]       w_head_data;
  logic              w_i_hit;
  logic [31:0]       w_i_fwd;
  logic              w_d_hit;
  logic [31:0]       w_d_fwd;

  assign w_i_idx = imemreq_addr[ADDR_W+1:2];
  assign w_d_idx = dmemreq_addr[ADDR_W+1:2];
  assign w_h_idx = hostreq_addr[ADDR_W+1:2];
  assign w_i_inr = in_range(imemreq_addr, ADDR_W);
  assign w_d_inr = in_range(dmemreq_addr, ADDR_W);
  assign w_h_inr = in_range(hostreq_addr, ADDR_W);

  // Write-port arbitration: a full buffer always drains and blocks the host;
  // otherwise the host has priority and the buffer drains only when idle.
  assign w_store   = dmemreq_val && (dmemreq_type == MEM_REQ_WRITE) && w_d_inr;
  assign w_full    = (w_count == CNT_W'(SB_DEPTH));
  assign w_drain   = w_full || (!hostreq_val && (w_count != '0));
  assign w_host_wr = !w_full && hostreq_val && w_h_inr;
  assign w_err_set = (imemreq_val && !w_i_inr) ||
                     (dmemreq_val && !w_d_inr) ||
                     (!w_full && hostreq_val && !w_h_inr);

  assign hostreq_rdy = !w_full;
  assign sb_count    = w_count;
  assign addr_err    = r_addr_err;

  store_buffer #(
    .ADDR_W   (ADDR_W),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_store),
    .i_push_idx  (w_d_idx),
    .i_push_data (dmemreq_wdata),
    .i_pop       (w_drain),
    .o_head_idx  (w_head_idx),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .i_lka_idx   (w_i_idx),
    .o_lka_hit   (w_i_hit),
    .o_lka_data  (w_i_fwd),
    .i_lkb_idx   (w_d_idx),
    .o_lkb_hit   (w_d_hit),
    .o_lkb_data  (w_d_fwd)
  );

  // Single RAM write port: buffer drain or accepted host write (never both).
  always_ff @(posedge clk) begin
    if (w_drain) begin
      r_ram[w_head_idx] <= w_head_data;
    end else if (w_host_wr) begin
      r_ram[w_h_idx] <= hostreq_wdata;
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_err <= 1'b0;
    end else if (w_err_set) begin
      r_addr_err <= 1'b1;
    end
  end

  // Instruction read: buffered data overrides RAM; same-cycle writes unseen.
  always_comb begin
    imemresp_data = '0;
    if (imemreq_val && w_i_inr) begin
      imemresp_data = w_i_hit ? w_i_fwd : r_ram[w_i_idx];
    end
  end

  // Data read: same rule as the instruction port.
  always_comb begin
    dmemresp_rdata = '0;
    if (dmemreq_val && w_d_inr) begin
      dmemresp_rdata = w_d_hit ? w_d_fwd : r_ram[w_d_idx];
    end
  end

endmodule
